// File: rtl/ram_loader.sv
// ram_loader
//   Boot-time controller that moves a host byte stream into the SAP-1 RAM
//   over the shared bus. It reuses the memory-address-in and RAM-in strobes
//   that the instruction decoder drives (the two sources are ORed outside
//   this block). It also holds the CPU halted until the whole image is in RAM.
//
//   Optional build macro: RAM_LOADER_VERIFY_EN
//     When defined, each word is read back after it is written (VERIFY state).
//     Any mismatch sets a sticky error flag and records the first bad
//     address. When undefined, o_ramo/o_error/o_err_addr are tied low.
//
// Ports
//   clk, rst       system clock, synchronous active-high reset
//   clk_en         shared clock enable; qualifies every state update
//   i_start        begin a load (sampled in IDLE only)
//   i_length       words to load, clamped to RAM_DEPTH
//   i_valid/i_data host word stream; o_ready = loader can take a word
//   i_ram_data     RAM read data (verify build only)
//   o_hold         halt request to the CPU
//   o_memaddri     load memory address register from bus
//   o_rami         write RAM from bus
//   o_ramo         RAM drives bus (verify build only)
//   o_bus_en       loader owns the bus; o_bus_data is its value (else 0)
//   o_busy         not IDLE
//   o_done         one clk_en cycle at the end of a load
//   o_count        words written in the current or last load
//   o_error        sticky verify mismatch; o_err_addr = first bad address
module ram_loader #(
    parameter int RAM_DEPTH = 16,
    parameter int RAM_WIDTH = 8,
    parameter int BUS_WIDTH = 8,
    localparam int ADDRESS_WIDTH = $clog2(RAM_DEPTH)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clk_en,
    input  logic                     i_start,
    input  logic [ADDRESS_WIDTH:0]   i_length,
    input  logic                     i_valid,
    input  logic [RAM_WIDTH-1:0]     i_data,
    output logic                     o_ready,
    input  logic [RAM_WIDTH-1:0]     i_ram_data,
    output logic                     o_hold,
    output logic                     o_memaddri,
    output logic                     o_rami,
    output logic                     o_ramo,
    output logic                     o_bus_en,
    output logic [BUS_WIDTH-1:0]     o_bus_data,
    output logic                     o_busy,
    output logic                     o_done,
    output logic [ADDRESS_WIDTH:0]   o_count,
    output logic                     o_error,
    output logic [ADDRESS_WIDTH-1:0] o_err_addr
);

    localparam logic [ADDRESS_WIDTH:0] DEPTH_LEN = (ADDRESS_WIDTH+1)'(RAM_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_WAIT_DATA = 3'd1,
        S_SET_ADDR  = 3'd2,
        S_WRITE     = 3'd3,
`ifdef RAM_LOADER_VERIFY_EN
        S_VERIFY    = 3'd4,
`endif
        S_DONE      = 3'd5
    } state_t;

    state_t                   state_reg;
    logic [ADDRESS_WIDTH:0]   len_reg;
    logic [ADDRESS_WIDTH-1:0] addr_reg;
    logic [RAM_WIDTH-1:0]     data_reg;
    logic [ADDRESS_WIDTH:0]   count_reg;

    logic [ADDRESS_WIDTH:0]   len_clamped;
    logic                     last_word;

    // Clamping the length up front guarantees addr never passes RAM_DEPTH-1.
    assign len_clamped = (i_length > DEPTH_LEN) ? DEPTH_LEN : i_length;
    // len_reg is never 0 outside IDLE/DONE, so len_reg-1 cannot underflow here.
    assign last_word   = ({1'b0, addr_reg} == (len_reg - 1'b1));

`ifdef RAM_LOADER_VERIFY_EN
    logic                     error_reg;
    logic [ADDRESS_WIDTH-1:0] err_addr_reg;
`else
    // Read-back data has no consumer without the verify state.
    logic unused_ram_data;
    assign unused_ram_data = ^i_ram_data;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= S_IDLE;
            len_reg   <= '0;
            addr_reg  <= '0;
            data_reg  <= '0;
            count_reg <= '0;
`ifdef RAM_LOADER_VERIFY_EN
            error_reg    <= 1'b0;
            err_addr_reg <= '0;
`endif
        end else if (clk_en) begin
            case (state_reg)
                S_IDLE: begin
                    if (i_start) begin
                        len_reg   <= len_clamped;
                        addr_reg  <= '0;
                        count_reg <= '0;
`ifdef RAM_LOADER_VERIFY_EN
                        error_reg    <= 1'b0;
                        err_addr_reg <= '0;
`endif
                        state_reg <= (len_clamped == '0) ? S_DONE : S_WAIT_DATA;
                    end
                end
                S_WAIT_DATA: begin
                    if (i_valid) begin
                        data_reg  <= i_data;
                        state_reg <= S_SET_ADDR;
                    end
                end
                S_SET_ADDR: begin
                    state_reg <= S_WRITE;
                end
                S_WRITE: begin
                    count_reg <= count_reg + 1'b1;
`ifdef RAM_LOADER_VERIFY_EN
                    state_reg <= S_VERIFY;
`else
                    if (last_word) begin
                        state_reg <= S_DONE;
                    end else begin
                        addr_reg  <= addr_reg + 1'b1;
                        state_reg <= S_WAIT_DATA;
                    end
`endif
                end
`ifdef RAM_LOADER_VERIFY_EN
                S_VERIFY: begin
                    // A mismatch is recorded but the load keeps going so the
                    // host sees the whole image written.
                    if (i_ram_data != data_reg) begin
                        error_reg <= 1'b1;
                        if (!error_reg) begin
                            err_addr_reg <= addr_reg;
                        end
                    end
                    if (last_word) begin
                        state_reg <= S_DONE;
                    end else begin
                        addr_reg  <= addr_reg + 1'b1;
                        state_reg <= S_WAIT_DATA;
                    end
                end
`endif
                S_DONE: begin
                    state_reg <= S_IDLE;
                end
                default: begin
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

    // Strobes are decoded from the state register. With clk_en low they stay
    // asserted, but the downstream registers ignore them in that case.
    always_comb begin
        o_ready    = (state_reg == S_WAIT_DATA);
        o_hold     = (state_reg != S_IDLE);
        o_busy     = (state_reg != S_IDLE);
        o_memaddri = (state_reg == S_SET_ADDR);
        o_rami     = (state_reg == S_WRITE);
        o_bus_en   = (state_reg == S_SET_ADDR) || (state_reg == S_WRITE);
        o_done     = (state_reg == S_DONE);
        o_bus_data = '0;
        if (state_reg == S_SET_ADDR) begin
            o_bus_data = BUS_WIDTH'(addr_reg);
        end else if (state_reg == S_WRITE) begin
            o_bus_data = BUS_WIDTH'(data_reg);
        end
    end

    assign o_count = count_reg;

`ifdef RAM_LOADER_VERIFY_EN
    assign o_ramo     = (state_reg == S_VERIFY);
    assign o_error    = error_reg;
    assign o_err_addr = err_addr_reg;
`else
    assign o_ramo     = 1'b0;
    assign o_error    = 1'b0;
    assign o_err_addr = '0;
`endif

endmodule

// File: tb/tb_ram_loader.sv
`timescale 1ns/1ps
module tb_ram_loader;

`ifdef RAM_LOADER_VERIFY_EN
    localparam int PW = 4;
`else
    localparam int PW = 3;
`endif

    logic       clk = 1'b0;
    logic       rst, clk_en, i_start, i_valid;
    logic [4:0] i_length;
    logic [7:0] i_data, i_ram_data;
    logic       o_ready, o_hold, o_memaddri, o_rami, o_ramo, o_bus_en;
    logic [7:0] o_bus_data;
    logic       o_busy, o_done, o_error;
    logic [4:0] o_count;
    logic [3:0] o_err_addr;

    always #5 clk = ~clk;

    ram_loader dut (
        .clk        (clk),
        .rst        (rst),
        .clk_en     (clk_en),
        .i_start    (i_start),
        .i_length   (i_length),
        .i_valid    (i_valid),
        .i_data     (i_data),
        .o_ready    (o_ready),
        .i_ram_data (i_ram_data),
        .o_hold     (o_hold),
        .o_memaddri (o_memaddri),
        .o_rami     (o_rami),
        .o_ramo     (o_ramo),
        .o_bus_en   (o_bus_en),
        .o_bus_data (o_bus_data),
        .o_busy     (o_busy),
        .o_done     (o_done),
        .o_count    (o_count),
        .o_error    (o_error),
        .o_err_addr (o_err_addr)
    );

    // Bench-side RAM and memory address register, fed by the loader strobes.
    logic [7:0] ram_model [16];
    logic [3:0] mar = 4'd0;
    logic       corrupt1 = 1'b0;
    assign i_ram_data = (corrupt1 && mar == 4'd1) ? 8'h00 : ram_model[mar];

    logic [7:0]  wdata [20];
    logic [11:0] sb_q [$];
    int n_cmp = 0;
    int n_err = 0;
    int n_writes = 0;
    int last_addr = -1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Monitor: samples at the falling edge, acts on strobes qualified by clk_en.
    always @(negedge clk) begin
        logic [11:0] exp_w;
        if (!rst && clk_en) begin
            if (!o_bus_en) chk("bus_idle_zero", o_bus_data, 0);
            if (o_memaddri) begin
                chk("bus_en_addr", o_bus_en, 1);
                mar = o_bus_data[3:0];
            end
            if (o_rami) begin
                chk("bus_en_write", o_bus_en, 1);
                chk("write_expected", (sb_q.size() != 0), 1);
                if (sb_q.size() != 0) begin
                    exp_w = sb_q.pop_front();
                    chk("write_addr_data", {mar, o_bus_data}, exp_w);
                end
                ram_model[mar] = o_bus_data;
                n_writes++;
                last_addr = int'(mar);
            end
        end
    end

    task automatic run_load(input string name, input int len, input int en_period,
                            input int gap_word, input int gap_len, input int rst_word,
                            input bit exp_err);
        int eff, e_cnt, widx, gap_left, tick, done_e, wr_base, exp_done;
        eff      = (len > 16) ? 16 : len;
        exp_done = PW * eff + 1 + gap_len;
        sb_q.delete();
        widx = 0; gap_left = gap_len; wr_base = n_writes; done_e = -1; tick = 0;
        @(posedge clk); #1;
        i_start = 1'b1; i_length = len[4:0]; clk_en = 1'b1; i_valid = 1'b0;
        @(posedge clk); #1;
        i_start = 1'b0; e_cnt = 1;
        for (int it = 0; it < 600; it++) begin
            if (rst_word >= 0 && o_rami && (n_writes - wr_base) == rst_word) begin
                rst = 1'b1; clk_en = 1'b1;
                @(posedge clk); #1;
                chk({name, "_hold"}, o_hold, 0);
                chk({name, "_busy"}, o_busy, 0);
                chk({name, "_count"}, o_count, 0);
                chk({name, "_strobes"}, {o_ready, o_memaddri, o_rami, o_bus_en}, 0);
                rst = 1'b0; i_valid = 1'b0;
                sb_q.delete();
                chk({name, "_ram0"}, ram_model[0], wdata[0]);
                chk({name, "_ram1"}, ram_model[1], wdata[1]);
                $display("%s: reset during write of word %0d", name, rst_word);
                return;
            end
            if (o_done && done_e < 0) done_e = e_cnt;
            if (e_cnt <= exp_done) chk({name, "_hold_on"}, o_hold, 1);
            if (done_e >= 0 && !o_busy) break;
            clk_en = ((tick % en_period) == 0);
            tick++;
            if (widx == gap_word && gap_left > 0 && (n_writes - wr_base) == gap_word) begin
                chk({name, "_gap_ready"}, o_ready, 1);
                i_valid = 1'b0;
                if (clk_en) gap_left--;
            end else begin
                i_valid = 1'b1;
            end
            i_data = wdata[(widx < 20) ? widx : 19];
            if (o_ready && i_valid && clk_en) begin
                sb_q.push_back({widx[3:0], wdata[widx]});
                widx++;
            end
            @(posedge clk);
            if (clk_en) e_cnt++;
            #1;
        end
        i_valid = 1'b0; clk_en = 1'b1;
        chk({name, "_done_cycle"}, done_e, exp_done);
        chk({name, "_finished"}, o_busy, 0);
        chk({name, "_hold_off"}, o_hold, 0);
        chk({name, "_count"}, o_count, eff);
        chk({name, "_nwrites"}, n_writes - wr_base, eff);
        chk({name, "_sb_empty"}, sb_q.size(), 0);
        chk({name, "_error"}, o_error, exp_err);
        if (exp_err) chk({name, "_err_addr"}, o_err_addr, 1);
        if (eff > 0) chk({name, "_last_addr"}, last_addr, eff - 1);
        $display("%s: len=%0d written=%0d done_cycle=%0d count=%0d", name, len,
                 n_writes - wr_base, done_e, o_count);
    endtask

    initial begin
        rst = 1'b1; clk_en = 1'b1; i_start = 1'b0; i_length = '0;
        i_valid = 1'b0; i_data = '0;
        for (int i = 0; i < 16; i++) ram_model[i] = 8'hFF;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_flags", {o_busy, o_hold, o_ready, o_done, o_memaddri, o_rami,
                            o_ramo, o_bus_en, o_error}, 0);
        chk("reset_count", o_count, 0);
        chk("reset_err_addr", o_err_addr, 0);
        chk("reset_bus", o_bus_data, 0);
        rst = 1'b0;
        $display("reset: outputs checked");

        wdata[0] = 8'h1E; wdata[1] = 8'h2F; wdata[2] = 8'hE0; wdata[3] = 8'hF0;
        for (int i = 4; i < 20; i++) wdata[i] = 8'(i * 29 + 7);

        run_load("basic", 4, 1, -1, 0, -1, 1'b0);
        run_load("clk_en_div4", 4, 4, -1, 0, -1, 1'b0);
        run_load("valid_gap", 4, 1, 2, 5, -1, 1'b0);
        run_load("len_zero", 0, 1, -1, 0, -1, 1'b0);
        for (int i = 0; i < 20; i++) wdata[i] = 8'(i * 53 + 11);
        run_load("len_clamp", 20, 1, -1, 0, -1, 1'b0);

        wdata[0] = 8'h1E; wdata[1] = 8'h2F; wdata[2] = 8'hE0; wdata[3] = 8'hF0;
        for (int i = 0; i < 16; i++) ram_model[i] = 8'hFF;
        run_load("reset_mid", 4, 1, -1, 0, 2, 1'b0);
        run_load("after_reset", 4, 1, -1, 0, -1, 1'b0);
`ifdef RAM_LOADER_VERIFY_EN
        corrupt1 = 1'b1;
        run_load("verify_err", 4, 1, -1, 0, -1, 1'b1);
        corrupt1 = 1'b0;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
